// File: rtl/mem_master_if.sv
// Request/response and exmemory-side signals of the mem_master bus initiator.
// The master modport is the initiator's view; the slave modport is the CPU/memory side.
interface mem_master_if #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 16
);
  logic                  req;
  logic                  req_write;
  logic [1:0]            req_size;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [WIDTH-1:0]      req_wdata;
  logic                  ready;
  logic                  done;
  logic                  err;
  logic [WIDTH-1:0]      rdata;
  logic                  MemWrite;
  logic [1:0]            MemMode;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic [WIDTH-1:0]      memWriteData;
  logic [WIDTH-1:0]      memReadData;

  modport master (
    input  req, req_write, req_size, req_addr, req_wdata, memReadData,
    output ready, done, err, rdata, MemWrite, MemMode, memAddr, memWriteData
  );

  modport slave (
    output req, req_write, req_size, req_addr, req_wdata, memReadData,
    input  ready, done, err, rdata, MemWrite, MemMode, memAddr, memWriteData
  );
endinterface

// File: rtl/mem_master.sv
// Bus initiator sequencing one load/store at a time onto exmemory, with alignment and
// ROM-write checks and read-modify-write for byte stores to RAM.
module mem_master #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  mem_master_if.master bus
);
  localparam int unsigned RW = 4;
  localparam logic [RW-1:0] REG_ROM = 4'h0;
  localparam logic [RW-1:0] REG_RAM = 4'h1;
  localparam logic [RW-1:0] REG_IO  = 4'hF;

  typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, DONE} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            size_q, size_d;
  logic                  write_q, write_d;
  logic [WIDTH-1:0]      wdata_q, wdata_d;
  logic                  ready_q, ready_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [WIDTH-1:0]      rdata_q, rdata_d;
  logic                  mem_write_q, mem_write_d;
  logic [1:0]            mem_mode_q, mem_mode_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0]      mem_wdata_q, mem_wdata_d;

  logic [RW-1:0]         req_region, addr_region;
  logic                  req_is_word, size_is_word;

  assign req_region   = bus.req_addr[ADDR_WIDTH-1 -: RW];
  assign req_is_word  = (bus.req_size[1] == bus.req_size[0]);

  // Next state, latched request and completion status
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    write_d = write_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req) begin
          addr_d  = bus.req_addr;
          size_d  = bus.req_size;
          write_d = bus.req_write;
          wdata_d = bus.req_wdata;
          if (req_is_word && (req_region == REG_ROM || req_region == REG_RAM) &&
              bus.req_addr[1:0] != 2'b00) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else if (bus.req_write && req_region == REG_ROM) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else if (!bus.req_write) begin
            state_d = RD;
          end else if (req_region == REG_RAM && !req_is_word) begin
            state_d = RMW_RD;
          end else begin
            state_d = WR;
          end
        end
      end
      RD: begin
        rdata_d = bus.memReadData;
        err_d   = 1'b0;
        state_d = DONE;
      end
      RMW_RD: begin
        // Merged word replaces wdata so WR can drive it unchanged
        wdata_d = bus.memReadData;
        wdata_d[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        state_d = WR;
      end
      WR: begin
        err_d   = 1'b0;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign addr_region  = addr_d[ADDR_WIDTH-1 -: RW];
  assign size_is_word = (size_d[1] == size_d[0]);

  // Outputs registered from the state being entered and the values latched with it
  always_comb begin
    ready_d     = (state_d == IDLE);
    done_d      = (state_d == DONE);
    mem_write_d = 1'b0;
    mem_mode_d  = 2'b00;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    unique case (state_d)
      RD: begin
        mem_addr_d = addr_d;
        mem_mode_d = size_is_word ? 2'b00 : size_d;
      end
      RMW_RD: mem_addr_d = {addr_d[ADDR_WIDTH-1:2], 2'b00};
      WR: begin
        mem_write_d = 1'b1;
        mem_addr_d  = addr_d;
        mem_wdata_d = (addr_region == REG_IO && !size_is_word) ? WIDTH'(wdata_d[7:0]) : wdata_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      size_q      <= 2'b00;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      mem_write_q <= 1'b0;
      mem_mode_q  <= 2'b00;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      mem_write_q <= mem_write_d;
      mem_mode_q  <= mem_mode_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.ready        = ready_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;
  assign bus.rdata        = rdata_q;
  assign bus.MemWrite     = mem_write_q;
  assign bus.MemMode      = mem_mode_q;
  assign bus.memAddr      = mem_addr_q;
  assign bus.memWriteData = mem_wdata_q;

endmodule

// File: tb/tb_mem_master.sv
// Directed bench for mem_master against a small exmemory model (RAM 0x1xxx, ROM 0x0xxx,
// IO at 0xfffc..0xffff with LEDs and switches).
module tb_mem_master;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_master_if #(.WIDTH(32), .ADDR_WIDTH(16)) bus ();

  mem_master #(.WIDTH(32), .ADDR_WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Memory model
  logic [31:0] ram [1024] = '{default: 32'h0};
  logic [15:0] leds = 16'h0;
  logic [15:0] switches = 16'h1234;
  logic [31:0] m_word;
  logic [7:0]  m_byte;

  always_comb begin
    if (bus.memAddr[15:12] == 4'h1)      m_word = ram[bus.memAddr[11:2]];
    else if (bus.memAddr[15:12] == 4'hF) m_word = {switches[15:8], switches[7:0], leds[15:8], leds[7:0]};
    else                                 m_word = 32'h0;
    m_byte = m_word[{bus.memAddr[1:0], 3'b000} +: 8];
    case (bus.MemMode)
      2'b01:   bus.memReadData = {{24{m_byte[7]}}, m_byte};
      2'b10:   bus.memReadData = {24'h0, m_byte};
      default: bus.memReadData = m_word;
    endcase
  end

  always @(posedge clk) begin
    if (bus.MemWrite) begin
      if (bus.memAddr[15:12] == 4'h1) ram[bus.memAddr[11:2]] <= bus.memWriteData;
      else if (bus.memAddr[15:12] == 4'hF && !bus.memAddr[1]) begin
        if (bus.memAddr[0]) leds[15:8] <= bus.memWriteData[7:0];
        else                leds[7:0]  <= bus.memWriteData[7:0];
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Results of the last transaction
  int          t_done_cyc, t_wr_cnt, t_wr_cyc;
  logic [15:0] t_wr_addr, t_c1_addr;
  logic [31:0] t_wr_data, t_rdata;
  logic [1:0]  t_c1_mode;
  logic        t_err, t_ready_after;

  task automatic run_req(input logic wr, input logic [1:0] sz, input logic [15:0] a,
                         input logic [31:0] d);
    bit got;
    @(negedge clk);
    for (int i = 0; i < 20 && !bus.ready; i++) @(negedge clk);
    bus.req = 1'b1; bus.req_write = wr; bus.req_size = sz; bus.req_addr = a; bus.req_wdata = d;
    t_done_cyc = 0; t_wr_cnt = 0; t_wr_cyc = 0; t_wr_addr = '0; t_wr_data = '0;
    t_err = 1'bx; t_rdata = 'x; got = 1'b0;
    for (int c = 1; c <= 6 && !got; c++) begin
      @(negedge clk);
      bus.req = 1'b0;
      if (c == 1) begin t_c1_addr = bus.memAddr; t_c1_mode = bus.MemMode; end
      if (bus.MemWrite) begin
        t_wr_cnt++; t_wr_cyc = c; t_wr_addr = bus.memAddr; t_wr_data = bus.memWriteData;
      end
      if (bus.done) begin
        got = 1'b1; t_done_cyc = c; t_err = bus.err; t_rdata = bus.rdata;
      end
    end
    if (!got) check("done_timeout", 32'(got), 32'd1);
    @(negedge clk);
    t_ready_after = bus.ready;
  endtask

  int mw_seen, done_seen;

  initial begin
    bus.req = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
    bus.req_addr = '0; bus.req_wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_memwrite", 32'(bus.MemWrite), 32'd0);
    check("rst_memaddr", 32'(bus.memAddr), 32'h0);
    check("rst_memmode", 32'(bus.MemMode), 32'h0);
    check("rst_memwdata", bus.memWriteData, 32'h0);
    reset = 1'b1;

    // sw 0x1004 <- 0xdeadbeef
    run_req(1'b1, 2'b00, 16'h1004, 32'hdeadbeef);
    check("sw_done_cyc", 32'(t_done_cyc), 32'd2);
    check("sw_wr_cnt", 32'(t_wr_cnt), 32'd1);
    check("sw_wr_cyc", 32'(t_wr_cyc), 32'd1);
    check("sw_wr_addr", 32'(t_wr_addr), 32'h1004);
    check("sw_wr_data", t_wr_data, 32'hdeadbeef);
    check("sw_err", 32'(t_err), 32'd0);
    check("sw_ready_after", 32'(t_ready_after), 32'd1);

    run_req(1'b0, 2'b00, 16'h1004, 32'h0);
    check("lw1_done_cyc", 32'(t_done_cyc), 32'd2);
    check("lw1_rdata", t_rdata, 32'hdeadbeef);
    check("lw1_err", 32'(t_err), 32'd0);
    check("lw1_wr_cnt", 32'(t_wr_cnt), 32'd0);

    // sb 0x1005 <- 0x55 via read-modify-write
    run_req(1'b1, 2'b01, 16'h1005, 32'h00000055);
    check("sb_rmw_addr", 32'(t_c1_addr), 32'h1004);
    check("sb_rmw_mode", 32'(t_c1_mode), 32'h0);
    check("sb_wr_cnt", 32'(t_wr_cnt), 32'd1);
    check("sb_wr_cyc", 32'(t_wr_cyc), 32'd2);
    check("sb_wr_data", t_wr_data, 32'hdead55ef);
    check("sb_done_cyc", 32'(t_done_cyc), 32'd3);

    run_req(1'b0, 2'b11, 16'h1004, 32'h0);
    check("lw2_mode", 32'(t_c1_mode), 32'h0);
    check("lw2_rdata", t_rdata, 32'hdead55ef);

    run_req(1'b0, 2'b01, 16'h1007, 32'h0);
    check("lb_1007", t_rdata, 32'hffffffde);
    run_req(1'b0, 2'b10, 16'h1007, 32'h0);
    check("lbu_1007", t_rdata, 32'h000000de);
    run_req(1'b0, 2'b01, 16'h1005, 32'h0);
    check("lb_1005", t_rdata, 32'h00000055);

    // Errors: misaligned word store, ROM store
    run_req(1'b1, 2'b00, 16'h1002, 32'hcafef00d);
    check("misal_done_cyc", 32'(t_done_cyc), 32'd1);
    check("misal_err", 32'(t_err), 32'd1);
    check("misal_wr_cnt", 32'(t_wr_cnt), 32'd0);
    check("misal_err_held", 32'(bus.err), 32'd1);
    run_req(1'b1, 2'b00, 16'h0100, 32'hcafef00d);
    check("rom_done_cyc", 32'(t_done_cyc), 32'd1);
    check("rom_err", 32'(t_err), 32'd1);
    check("rom_wr_cnt", 32'(t_wr_cnt), 32'd0);
    run_req(1'b0, 2'b00, 16'h1004, 32'h0);
    check("lw3_err", 32'(t_err), 32'd0);
    check("lw3_rdata", t_rdata, 32'hdead55ef);

    // IO byte store and switch reads
    run_req(1'b1, 2'b01, 16'hfffd, 32'hffffffa5);
    check("io_wr_cnt", 32'(t_wr_cnt), 32'd1);
    check("io_wr_addr", 32'(t_wr_addr), 32'hfffd);
    check("io_wr_data", t_wr_data, 32'h000000a5);
    check("io_done_cyc", 32'(t_done_cyc), 32'd2);
    check("io_leds", 32'(leds), 32'h0000a500);
    check("io_rdata_held", bus.rdata, 32'hdead55ef);
    run_req(1'b0, 2'b10, 16'hfffe, 32'h0);
    check("lbu_fffe", t_rdata, 32'h00000034);
    run_req(1'b0, 2'b10, 16'hffff, 32'h0);
    check("lbu_ffff", t_rdata, 32'h00000012);

    // Reset abort during RMW_RD
    run_req(1'b1, 2'b00, 16'h1008, 32'h11223344);
    check("pre_wr_cnt", 32'(t_wr_cnt), 32'd1);
    @(negedge clk);
    bus.req = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b01;
    bus.req_addr = 16'h1008; bus.req_wdata = 32'h000000ff;
    @(negedge clk);
    bus.req = 1'b0;
    check("abort_rmw_addr", 32'(bus.memAddr), 32'h1008);
    check("abort_c1_memwrite", 32'(bus.MemWrite), 32'd0);
    #1 reset = 1'b0;
    #1;
    check("abort_ready", 32'(bus.ready), 32'd1);
    check("abort_memaddr", 32'(bus.memAddr), 32'h0);
    mw_seen = 0; done_seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.MemWrite) mw_seen++;
      if (bus.done) done_seen++;
    end
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (bus.MemWrite) mw_seen++;
      if (bus.done) done_seen++;
    end
    check("abort_memwrite_seen", 32'(mw_seen), 32'd0);
    check("abort_done_seen", 32'(done_seen), 32'd0);
    check("abort_ready_after", 32'(bus.ready), 32'd1);
    run_req(1'b0, 2'b00, 16'h1008, 32'h0);
    check("abort_lw_rdata", t_rdata, 32'h11223344);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_master.md
# mem_master

Bus initiator that drives the exmemory port on behalf of the CPU datapath. It accepts one load or store request at a time and sequences it onto the memory interface (MemWrite, MemMode, memAddr, memWriteData, memReadData). The memory side only supports word writes to RAM, so byte stores to RAM (0x1xxx) are done as read-modify-write. The block sits between the multicycle controller/datapath and exmemory. It also checks alignment and blocks writes to ROM.

## Interface
Parameters:
- WIDTH, 32, data width
- ADDR_WIDTH, 16, byte address width (region = addr[15:12])

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- req  in  1  request strobe, sampled only while ready=1
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 word, 01 byte signed, 10 byte unsigned (11 treated as 00)
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  WIDTH  store data (a byte store uses [7:0])
- ready  out  1  idle, can accept a request
- done  out  1  one-cycle completion pulse
- err  out  1  error status of the last completed request; valid while done=1 and held until the next done
- rdata  out  WIDTH  load result, held until the next load completes
- MemWrite  out  1  memory write enable
- MemMode  out  2  memory read mode (same encoding as req_size)
- memAddr  out  ADDR_WIDTH  memory address
- memWriteData  out  WIDTH  memory write data
- memReadData  in  WIDTH  memory read data (combinational from memAddr/MemMode)

## Operation
- FSM states: IDLE, RD, RMW_RD, WR, DONE.
- Reset values:
  - state IDLE, ready 1, done 0, err 0, rdata 0.
  - MemWrite 0, MemMode 00, memAddr 0, memWriteData 0.
- In IDLE, a request with req=1 is latched (addr, size, write, wdata). The next state is chosen by the first matching rule:
  - Word access (size 00/11) to region 0x0 or 0x1 with addr[1:0]≠00: go to DONE with err=1. No memory cycle.
  - Store to region 0x0 (ROM): go to DONE with err=1. No memory cycle.
  - Load (any region): go to RD.
  - Byte store to region 0x1: go to RMW_RD.
  - Any other store (word store to 0x1, any store to 0xF, other regions): go to WR.
- RD:
  - Drive memAddr = latched addr, MemMode = latched size (11 driven as 00), MemWrite 0.
  - On the clock edge, capture memReadData into rdata. Next state DONE, err=0.
- RMW_RD:
  - Drive memAddr = {addr[15:2],2'b00}, MemMode 00.
  - On the clock edge, merge wdata[7:0] into the captured word at byte lane addr[1:0]. All other lanes are preserved.
  - Next state WR.
- WR:
  - MemWrite=1 for exactly one cycle. memAddr = latched addr, MemMode 00.
  - memWriteData is:
    - merged word, after RMW_RD;
    - {24'b0, wdata[7:0]} for byte stores to region 0xF;
    - wdata otherwise.
  - Next state DONE, err=0.
- DONE: done=1 and ready=0. Next state IDLE.
- Outside RD/RMW_RD/WR, memory outputs return to their idle values (MemWrite 0, MemMode 00, memAddr 0, memWriteData 0).
- Stores to 0xF do not check alignment (IO uses byte addresses 0xfffc/0xfffd).
- Loads from unmapped regions complete normally. rdata takes whatever memReadData holds.
- req while ready=0 is ignored. It is not queued.

## Timing
Cycle 0 is the IDLE cycle in which req is sampled.
- Load: RD in cycle 1. done and valid rdata in cycle 2.
- Word store or IO store: MemWrite in cycle 1. done in cycle 2.
- Byte store to RAM: RMW_RD in cycle 1, MemWrite in cycle 2, done in cycle 3.
- Error: done=1 with err=1 in cycle 1. MemWrite is never asserted.
- ready returns to 1 the cycle after done. Back-to-back requests therefore start at least 1 cycle apart after done.
- Memory outputs are combinational from state and latched registers only. They never depend on req_* in the same cycle.
- Reset asserted mid-operation:
  - All outputs go to their reset values immediately, including MemWrite 0.
  - No done is produced and the in-flight request is dropped.
  - A write is performed only if its posedge occurred before reset was asserted.

## Test plan
- Word store then load, RAM cleared:
  - sw 0x1004 ← 0xdeadbeef gives exactly one MemWrite in cycle 1 with memAddr 0x1004 and done in cycle 2.
  - lw 0x1004 then gives done in cycle 2 with rdata 0xdeadbeef and err 0.
- Byte store to RAM over that word:
  - sb 0x1005 ← 0x55 gives an RMW_RD read at 0x1004, a single MemWrite of 0xdead55ef in cycle 2, and done in cycle 3.
  - lw 0x1004 → 0xdead55ef.
- Byte loads:
  - lb 0x1007 → 0xffffffde; lbu 0x1007 → 0x000000de; lb 0x1005 → 0x00000055.
- Errors:
  - sw 0x1002 gives done with err=1 in cycle 1 and no MemWrite.
  - sw 0x0100 (ROM) gives the same.
  - A following valid lw clears err to 0.
- IO:
  - sb 0xfffd ← 0xa5 gives one MemWrite with memAddr 0xfffd and memWriteData 0x000000a5; leds[15:8] = 0xa5.
  - With switches = 0x1234, lbu 0xfffe → 0x00000034 and lbu 0xffff → 0x00000012.
- Reset abort:
  - Preset 0x1008 = 0x11223344, then issue sb 0x1008 ← 0xff.
  - Assert reset during RMW_RD: MemWrite stays 0 and no done pulse.
  - After release, ready=1, and lw 0x1008 → 0x11223344.
